// File: rtl/sparse_idx_streamer_12.sv
// -----------------------------------------------------------------------------
// sparse_idx_streamer_12
//
// Expands a 12-bit nonzero mask into a stream of set-bit indices, lowest index
// first, one index per accepted output beat. Each beat carries the popcount of
// the whole mask and the beat's position within it. Valid/ready on both sides.
// A new mask can be accepted in the same cycle as the final beat of the
// previous one, so masks can be streamed with no gap between them.
//
// Optional feature macro: SPARSE_IDX_EMPTY_BEAT_EN
//   defined   : an all-zero mask produces one marker beat (out_empty_o=1).
//   undefined : an all-zero mask is consumed with no output beat.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   in_mask_i is valid
//   in_ready_o   a new mask can be accepted this cycle
//   in_mask_i    [11:0] nonzero mask, bit i <-> element index i
//   out_valid_o  output beat is valid
//   out_ready_i  consumer accepts the current beat
//   out_idx_o    [3:0] index of the current set bit (0..11)
//   out_cnt_o    [3:0] popcount of the mask being streamed (0..12)
//   out_seq_o    [3:0] beat number within the mask (0..cnt-1)
//   out_last_o   current beat is the last beat of the mask
//   out_empty_o  current beat is an empty-mask marker
// -----------------------------------------------------------------------------
module sparse_idx_streamer_12 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [11:0] in_mask_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [3:0]  out_idx_o,
   output logic [3:0]  out_cnt_o,
   output logic [3:0]  out_seq_o,
   output logic        out_last_o,
   output logic        out_empty_o
);

`ifdef SPARSE_IDX_EMPTY_BEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_EMPTY  = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1
   } state_e;
`endif

   state_e      state_q, state_d;
   logic [11:0] rem_q, rem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  seq_q, seq_d;

   logic [3:0]  low_idx;
   logic        rem_one_hot;
   logic        accept;
   logic        beat_xfer;

   // exact population count of a 12-bit vector (0..12 fits in 4 bits)
   function automatic logic [3:0] popcnt12(input logic [11:0] v);
      logic [3:0] sum;
      sum = 4'd0;
      for (int i = 0; i < 12; i++) begin
         sum = sum + {3'b000, v[i]};
      end
      return sum;
   endfunction

   // priority encoder: scanning from the top down leaves the lowest set index
   always_comb begin
      low_idx = 4'd0;
      for (int i = 11; i >= 0; i--) begin
         if (rem_q[i]) begin
            low_idx = i[3:0];
         end
      end
   end

   // exactly one bit left: nonzero and clearing the lowest bit leaves nothing
   assign rem_one_hot = (rem_q != 12'd0) && ((rem_q & (rem_q - 12'd1)) == 12'd0);

   // ---------------------------------------------------------------------------
   // outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_idx_o   = 4'd0;
      out_cnt_o   = 4'd0;
      out_seq_o   = 4'd0;
      out_last_o  = 1'b0;
      out_empty_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
         end
         ST_STREAM: begin
            out_valid_o = 1'b1;
            out_idx_o   = low_idx;
            out_cnt_o   = cnt_q;
            out_seq_o   = seq_q;
            out_last_o  = rem_one_hot;
            // next mask may only enter as the final beat leaves
            in_ready_o  = out_ready_i && rem_one_hot;
         end
`ifdef SPARSE_IDX_EMPTY_BEAT_EN
         ST_EMPTY: begin
            out_valid_o = 1'b1;
            out_last_o  = 1'b1;
            out_empty_o = 1'b1;
            in_ready_o  = out_ready_i;
         end
`endif
         default: begin
            in_ready_o = 1'b1;
         end
      endcase
   end

   assign accept    = in_valid_i && in_ready_o;
   assign beat_xfer = out_valid_o && out_ready_i;

   // ---------------------------------------------------------------------------
   // next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      seq_d   = seq_q;

      case (state_q)
         ST_STREAM: begin
            if (beat_xfer) begin
               rem_d = rem_q & (rem_q - 12'd1);
               seq_d = seq_q + 4'd1;
               if (rem_one_hot) begin
                  state_d = ST_IDLE;
               end
            end
         end
`ifdef SPARSE_IDX_EMPTY_BEAT_EN
         ST_EMPTY: begin
            if (beat_xfer) begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: ;
      endcase

      // a newly accepted mask overrides the end-of-mask return to idle
      if (accept) begin
         rem_d = in_mask_i;
         cnt_d = popcnt12(in_mask_i);
         seq_d = 4'd0;
         if (in_mask_i != 12'd0) begin
            state_d = ST_STREAM;
         end else begin
`ifdef SPARSE_IDX_EMPTY_BEAT_EN
            state_d = ST_EMPTY;
`else
            state_d = ST_IDLE;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         rem_q   <= 12'd0;
         cnt_q   <= 4'd0;
         seq_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
      end
   end

endmodule
